// File: rtl/brew_pkg.sv
// rtl/brew_pkg.sv - shared constants, FSM state type and gene slicing helper
package brew_pkg;

    localparam int NUM_CITIES   = 15;
    localparam int CITY_BITS    = 4;
    localparam int DEF_POP_SIZE = 125;
    localparam int GENE_BITS    = NUM_CITIES * CITY_BITS;

    // City count widened by one bit so an all-ones index compares cleanly.
    localparam logic [CITY_BITS:0] NUM_CITIES_W = (CITY_BITS + 1)'(NUM_CITIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ACC,
        S_EMIT,
        S_DONE
    } state_t;

    // City j of one chromosome.
    function automatic logic [CITY_BITS-1:0] gene_city(input logic [GENE_BITS-1:0] gene,
                                                       input int j);
        return gene[j*CITY_BITS +: CITY_BITS];
    endfunction

endpackage

// File: rtl/tour_edge_acc.sv
// rtl/tour_edge_acc.sv - edge walker with delayed-valid saturating tour accumulator
module tour_edge_acc
    import brew_pkg::*;
#(
    parameter int CLOSE_TOUR = 0,
    parameter int DIST_W     = 16,
    parameter int ACC_W      = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic [GENE_BITS-1:0] i_gene,
    input  logic [DIST_W-1:0]    i_dist_data,
    output logic [CITY_BITS-1:0] o_dist_a,
    output logic [CITY_BITS-1:0] o_dist_b,
    output logic                 o_last_edge,
    output logic [ACC_W-1:0]     o_result
);

    localparam int EDGES = NUM_CITIES - 1 + CLOSE_TOUR;
    localparam int EW    = (EDGES > 1) ? $clog2(EDGES) : 1;

    logic [EW-1:0]        r_edge;
    logic                 r_pend;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_bad;

    int                   w_next_pos;
    logic [CITY_BITS-1:0] w_ca;
    logic [CITY_BITS-1:0] w_cb;
    logic                 w_bad_edge;
    logic [ACC_W:0]       w_wide;
    logic [ACC_W-1:0]     w_sum;

    // Edge endpoints, invalid-city detection, table address and saturating sum.
    always_comb begin
        w_next_pos  = (int'(r_edge) == NUM_CITIES - 1) ? 0 : int'(r_edge) + 1;
        w_ca        = gene_city(i_gene, int'(r_edge));
        w_cb        = gene_city(i_gene, w_next_pos);
        w_bad_edge  = ({1'b0, w_ca} >= NUM_CITIES_W) || ({1'b0, w_cb} >= NUM_CITIES_W);
        o_dist_a    = (i_run && !w_bad_edge) ? w_ca : '0;
        o_dist_b    = (i_run && !w_bad_edge) ? w_cb : '0;
        o_last_edge = i_run && (r_edge == EW'(EDGES - 1));
        w_wide      = {1'b0, r_acc} + {{(ACC_W + 1 - DIST_W){1'b0}}, i_dist_data};
        w_sum       = w_wide[ACC_W] ? '1 : w_wide[ACC_W-1:0];
        o_result    = r_bad ? '1 : w_sum;
    end

    // Table data arrives one cycle after its address, so the add lags the edge by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge <= '0;
            r_pend <= 1'b0;
            r_acc  <= '0;
            r_bad  <= 1'b0;
        end else begin
            r_pend <= i_run;
            if (i_run) begin
                r_edge <= o_last_edge ? '0 : r_edge + 1'b1;
            end
            if (i_run && (r_edge == '0)) begin
                r_acc <= '0;
                r_bad <= w_bad_edge;
            end else begin
                if (r_pend) begin
                    r_acc <= w_sum;
                end
                if (i_run) begin
                    r_bad <= r_bad | w_bad_edge;
                end
            end
        end
    end

endmodule

// File: rtl/comp_distance_pop_stream.sv
// rtl/comp_distance_pop_stream.sv - population tour-length streamer with best tracker
module comp_distance_pop_stream
    import brew_pkg::*;
#(
    parameter int POP_SIZE   = DEF_POP_SIZE,
    parameter int DIST_W     = 16,
    parameter int ACC_W      = 20,
    parameter int CLOSE_TOUR = 0,
    parameter int IW         = $clog2(POP_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [POP_SIZE*GENE_BITS-1:0] pop,
    output logic                          busy,
    output logic                          done,
    output logic [CITY_BITS-1:0]          dist_a,
    output logic [CITY_BITS-1:0]          dist_b,
    input  logic [DIST_W-1:0]             dist_data,
    output logic                          fit_valid,
    input  logic                          fit_ready,
    output logic [IW-1:0]                 fit_idx,
    output logic [ACC_W-1:0]              fit_dist,
    output logic [IW-1:0]                 best_idx,
    output logic [ACC_W-1:0]              best_dist
);

    logic [POP_SIZE*GENE_BITS-1:0] r_shadow;
    state_t                        r_state;
    state_t                        w_state_nx;
    logic [IW-1:0]                 r_ind;
    logic [IW-1:0]                 r_fit_idx;
    logic [ACC_W-1:0]              r_fit_dist;
    logic [IW-1:0]                 r_best_idx;
    logic [ACC_W-1:0]              r_best_dist;

    logic [GENE_BITS-1:0]          w_gene;
    logic                          w_run;
    logic                          w_last_edge;
    logic                          w_hs;
    logic                          w_last_ind;
    logic [ACC_W-1:0]              w_result;

    assign w_gene     = r_shadow[int'(r_ind)*GENE_BITS +: GENE_BITS];
    assign w_run      = (r_state == S_RUN);
    assign w_hs       = (r_state == S_EMIT) && fit_ready;
    assign w_last_ind = (r_ind == IW'(POP_SIZE - 1));

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign fit_valid = (r_state == S_EMIT);
    assign fit_idx   = r_fit_idx;
    assign fit_dist  = r_fit_dist;
    assign best_idx  = r_best_idx;
    assign best_dist = r_best_dist;

    tour_edge_acc #(
        .CLOSE_TOUR (CLOSE_TOUR),
        .DIST_W     (DIST_W),
        .ACC_W      (ACC_W)
    ) u_edge_acc (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_run),
        .i_gene      (w_gene),
        .i_dist_data (dist_data),
        .o_dist_a    (dist_a),
        .o_dist_b    (dist_b),
        .o_last_edge (w_last_edge),
        .o_result    (w_result)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state: walk edges, finish last add, hold result until accepted.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_RUN;
            S_RUN:   if (w_last_edge) w_state_nx = S_ACC;
            S_ACC:   w_state_nx = S_EMIT;
            S_EMIT:  if (fit_ready) w_state_nx = w_last_ind ? S_DONE : S_RUN;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Snapshot, individual counter, result register and best-so-far tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_ind       <= '0;
            r_fit_idx   <= '0;
            r_fit_dist  <= '0;
            r_best_idx  <= '0;
            r_best_dist <= '1;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_shadow    <= pop;
                r_ind       <= '0;
                r_best_idx  <= '0;
                r_best_dist <= '1;
            end
            if (r_state == S_ACC) begin
                r_fit_idx  <= r_ind;
                r_fit_dist <= w_result;
            end
            if (w_hs) begin
                if (r_fit_dist < r_best_dist) begin
                    r_best_idx  <= r_fit_idx;
                    r_best_dist <= r_fit_dist;
                end
                if (!w_last_ind) begin
                    r_ind <= r_ind + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_distance_pop_stream.sv
// tb/tb_comp_distance_pop_stream.sv - randomized self-checking bench against a tour-length model
module tb_comp_distance_pop_stream;
    import brew_pkg::*;

    localparam int POP = DEF_POP_SIZE;
    localparam int GB  = GENE_BITS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [POP*GB-1:0] pop;
    logic              fit_ready0;
    logic              fit_ready1;

    logic        busy0, done0, fv0, busy1, done1, fv1;
    logic [3:0]  da0, db0, da1, db1;
    logic [15:0] dd0, dd1;
    logic [6:0]  fi0, bi0, fi1, bi1;
    logic [19:0] fd0, bd0, fd1, bd1;

    logic [15:0] dtab [16][16];
    logic [19:0] exp0 [POP];
    logic [19:0] exp1 [POP];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dd0 <= dtab[da0][db0];
        dd1 <= dtab[da1][db1];
    end

    comp_distance_pop_stream #(.POP_SIZE(POP), .DIST_W(16), .ACC_W(20), .CLOSE_TOUR(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .pop(pop), .busy(busy0), .done(done0),
        .dist_a(da0), .dist_b(db0), .dist_data(dd0), .fit_valid(fv0), .fit_ready(fit_ready0),
        .fit_idx(fi0), .fit_dist(fd0), .best_idx(bi0), .best_dist(bd0));

    comp_distance_pop_stream #(.POP_SIZE(POP), .DIST_W(16), .ACC_W(20), .CLOSE_TOUR(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .pop(pop), .busy(busy1), .done(done1),
        .dist_a(da1), .dist_b(db1), .dist_data(dd1), .fit_valid(fv1), .fit_ready(fit_ready1),
        .fit_idx(fi1), .fit_dist(fd1), .best_idx(bi1), .best_dist(bd1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Tour length straight from the chromosome: sum of table lookups along the path.
    function automatic logic [19:0] model_fit(input logic [GB-1:0] g, input int close);
        int c [15];
        int s;
        s = 0;
        for (int j = 0; j < 15; j++) begin
            c[j] = int'(g[j*4 +: 4]);
            if (c[j] >= 15) return 20'hFFFFF;
        end
        for (int j = 0; j < 14; j++) s += int'(dtab[c[j]][c[j+1]]);
        if (close != 0) s += int'(dtab[c[14]][c[0]]);
        return (s > 32'h000FFFFF) ? 20'hFFFFF : 20'(s);
    endfunction

    task automatic set_city(input int i, input int j, input int c);
        pop[i*GB + j*4 +: 4] = 4'(c);
    endtask

    task automatic set_identity(input int i, input bit reversed);
        for (int j = 0; j < 15; j++) set_city(i, j, reversed ? 14 - j : j);
    endtask

    task automatic set_rand_perm(input int i, input bit avoid_monotone);
        int c [15];
        int k, t;
        bit mono_up, mono_dn;
        for (int j = 0; j < 15; j++) c[j] = j;
        for (int j = 14; j > 0; j--) begin
            k = int'($urandom_range(0, j));
            t = c[j]; c[j] = c[k]; c[k] = t;
        end
        if (avoid_monotone) begin
            mono_up = 1'b1; mono_dn = 1'b1;
            for (int j = 0; j < 14; j++) begin
                if (c[j+1] != c[j] + 1) mono_up = 1'b0;
                if (c[j+1] != c[j] - 1) mono_dn = 1'b0;
            end
            if (mono_up || mono_dn) begin
                t = c[0]; c[0] = c[1]; c[1] = t;
            end
        end
        for (int j = 0; j < 15; j++) set_city(i, j, c[j]);
    endtask

    task automatic set_abs_table();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                dtab[a][b] = 16'((a > b) ? a - b : b - a);
    endtask

    task automatic set_rand_table();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                dtab[a][b] = 16'($urandom_range(0, 4095));
    endtask

    task automatic randomize_pop(input bit with_invalid);
        for (int i = 0; i < POP; i++) begin
            set_rand_perm(i, 1'b0);
            if (with_invalid && ($urandom_range(0, 7) == 0))
                set_city(i, int'($urandom_range(0, 14)), 15);
        end
    endtask

    // mode 0: ready high; 1: ready low 5 cycles at EMIT of stall_at; 2: random ready.
    task automatic run_pop(input int mode, input int stall_at, input bit disturb, input int rst_at);
        logic [19:0] bd_m0, bd_m1;
        int          bi_m0, bi_m1;
        int          cyc, hs0, hs1, stalls0, stall_cnt, done_cyc0;
        bit          d0, d1, stalled, was_stall, aborted, saw_done;
        logic [6:0]  p_idx;
        logic [19:0] p_dist;
        logic [3:0]  p_da, p_db;

        bd_m0 = 20'hFFFFF; bd_m1 = 20'hFFFFF; bi_m0 = 0; bi_m1 = 0;
        for (int i = 0; i < POP; i++) begin
            exp0[i] = model_fit(pop[i*GB +: GB], 0);
            exp1[i] = model_fit(pop[i*GB +: GB], 1);
            if (exp0[i] < bd_m0) begin bd_m0 = exp0[i]; bi_m0 = i; end
            if (exp1[i] < bd_m1) begin bd_m1 = exp1[i]; bi_m1 = i; end
        end

        cyc = 0; hs0 = 0; hs1 = 0; stalls0 = 0; stall_cnt = 0; done_cyc0 = 0;
        d0 = 0; d1 = 0; stalled = 0; was_stall = 0; aborted = 0; saw_done = 0;
        p_idx = '0; p_dist = '0; p_da = '0; p_db = '0;
        fit_ready0 = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (!(d0 && d1 && cyc > done_cyc0) && !aborted && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (fv0 && fit_ready0) begin
                if (hs0 < POP) begin
                    check("fit_idx0", 32'(fi0), 32'(hs0));
                    check("fit_dist0", 32'(fd0), 32'(exp0[hs0]));
                end
                hs0++;
            end
            if (fv0 && !fit_ready0) begin
                if (was_stall) begin
                    check("hold_idx", 32'(fi0), 32'(p_idx));
                    check("hold_dist", 32'(fd0), 32'(p_dist));
                    check("hold_dist_a", 32'(da0), 32'(p_da));
                    check("hold_dist_b", 32'(db0), 32'(p_db));
                end
                stalls0++;
            end
            was_stall = fv0 && !fit_ready0;
            p_idx = fi0; p_dist = fd0; p_da = da0; p_db = db0;
            if (fv1) begin
                if (hs1 < POP) begin
                    check("fit_idx1", 32'(fi1), 32'(hs1));
                    check("fit_dist1", 32'(fd1), 32'(exp1[hs1]));
                end
                hs1++;
            end
            if (d0 && cyc == done_cyc0 + 1) begin
                check("busy_after_done0", 32'(busy0), 32'd0);
                check("done_pulse0", 32'(done0), 32'd0);
            end
            if (done0 && !d0) begin
                d0 = 1; done_cyc0 = cyc;
                check("cycles0", 32'(cyc), 32'(POP*16 + 1 + stalls0));
            end
            if (done1 && !d1) begin
                d1 = 1;
                check("cycles1", 32'(cyc), 32'(POP*17 + 1));
            end
            if (rst_at >= 0 && hs0 == rst_at) begin
                rst = 1'b1;
                #1;
                check("abort_busy", 32'(busy0), 32'd0);
                check("abort_valid", 32'(fv0), 32'd0);
                check("abort_idx", 32'(fi0), 32'd0);
                check("abort_dist", 32'(fd0), 32'd0);
                check("abort_best_idx", 32'(bi0), 32'd0);
                check("abort_best_dist", 32'(bd0), 32'h000FFFFF);
                check("abort_dist_a", 32'(da0), 32'd0);
                check("abort_done", 32'(done0), 32'd0);
                aborted = 1;
            end
            if (!aborted) begin
                @(posedge clk); #1;
                case (mode)
                    1: begin
                        if (!stalled && fv0 && fi0 == 7'(stall_at)) begin
                            fit_ready0 = 1'b0; stall_cnt = 5; stalled = 1;
                        end else if (stall_cnt > 0) begin
                            stall_cnt--;
                            if (stall_cnt == 0) fit_ready0 = 1'b1;
                        end
                    end
                    2: fit_ready0 = 1'($urandom_range(0, 1));
                    default: fit_ready0 = 1'b1;
                endcase
                start = disturb && (cyc == 300);
                if (disturb && cyc == 300) randomize_pop(1'b0);
            end
        end

        if (aborted) begin
            repeat (3) begin
                @(negedge clk);
                if (done0) saw_done = 1;
            end
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (done0) saw_done = 1;
            end
            check("no_done_after_rst", 32'(saw_done), 32'd0);
            check("idle_after_rst", 32'(busy0), 32'd0);
        end else begin
            check("done0_seen", 32'(d0), 32'd1);
            check("done1_seen", 32'(d1), 32'd1);
            check("hs_count0", 32'(hs0), 32'(POP));
            check("hs_count1", 32'(hs1), 32'(POP));
            check("best_idx0", 32'(bi0), 32'(bi_m0));
            check("best_dist0", 32'(bd0), 32'(bd_m0));
            check("best_idx1", 32'(bi1), 32'(bi_m1));
            check("best_dist1", 32'(bd1), 32'(bd_m1));
        end
        fit_ready0 = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pop = '0; fit_ready0 = 1'b1; fit_ready1 = 1'b1;
        set_abs_table();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_valid", 32'(fv0), 32'd0);
        check("rst_fit_idx", 32'(fi0), 32'd0);
        check("rst_fit_dist", 32'(fd0), 32'd0);
        check("rst_best_idx", 32'(bi0), 32'd0);
        check("rst_best_dist", 32'(bd0), 32'h000FFFFF);
        check("rst_dist_a", 32'(da0), 32'd0);
        check("rst_dist_b", 32'(db0), 32'd0);
        @(posedge clk); #1;

        // Every individual is the identity tour.
        for (int i = 0; i < POP; i++) set_identity(i, 1'b0);
        run_pop(0, -1, 1'b0, -1);
        check("identity_open", 32'(bd0), 32'd14);
        check("identity_closed", 32'(bd1), 32'd28);
        check("identity_best_idx", 32'(bi0), 32'd0);

        // Individual 7 reversed, the rest scrambled; stall EMIT of individual 3.
        for (int i = 0; i < POP; i++) set_rand_perm(i, 1'b1);
        set_identity(7, 1'b1);
        run_pop(1, 3, 1'b0, -1);
        check("reversed_best_idx", 32'(bi0), 32'd7);
        check("reversed_best_dist", 32'(bd0), 32'd14);

        // Individual 2 holds city 15; restart and pop change mid-run.
        for (int i = 0; i < POP; i++) set_rand_perm(i, 1'b1);
        set_identity(2, 1'b0);
        set_city(2, 6, 15);
        run_pop(0, -1, 1'b1, -1);
        check("invalid_not_best", 32'(bi0 != 7'd2), 32'd1);

        // Reset during individual 50, then a full run.
        randomize_pop(1'b0);
        run_pop(0, -1, 1'b0, 50);
        set_rand_table();
        randomize_pop(1'b1);
        run_pop(0, -1, 1'b0, -1);

        // Random table, random population, random backpressure.
        set_rand_table();
        randomize_pop(1'b1);
        run_pop(2, -1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
